// File: rtl/ontransit_rr_arb.sv
// ontransit_rr_arb: round-robin burst arbiter with on-transit registered outputs.
// Grants one requester for at most MAXBURST cycles, then takes a turnaround
// (LAST, IDLE) and restarts the rotating priority after the previous owner.
module ontransit_rr_arb #(
    parameter int NREQ     = 4,
    parameter int MAXBURST = 8,
    parameter int IDW      = $clog2(NREQ),
    parameter int CW       = $clog2(MAXBURST + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            last_beat,
    output logic            done,
    output logic            busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_LAST = 2'd2;

    localparam int unsigned     NREQ_U  = NREQ;
    localparam logic [IDW:0]    NREQ_W  = (IDW + 1)'(NREQ);
    localparam logic [CW-1:0]   MAXB_C  = CW'(MAXBURST);
    localparam logic [IDW-1:0]  LAST_ID = IDW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE_N   = {{(NREQ - 1){1'b0}}, 1'b1};

    logic [1:0]      r_state;
    logic [IDW-1:0]  r_owner;
    logic [IDW-1:0]  r_ptr;
    logic [CW-1:0]   r_cnt;
    logic [NREQ-1:0] r_gnt;
    logic [IDW-1:0]  r_gnt_id;
    logic            r_last_beat;
    logic            r_done;

    logic            w_found;
    logic [IDW-1:0]  w_winner;

    logic [1:0]      w_nxt_state;
    logic [IDW-1:0]  w_nxt_owner;
    logic [IDW-1:0]  w_nxt_ptr;
    logic [CW-1:0]   w_nxt_cnt;
    logic [NREQ-1:0] w_nxt_gnt;
    logic [IDW-1:0]  w_nxt_gnt_id;
    logic            w_nxt_last_beat;
    logic            w_nxt_done;

    // Winner search: first set request at or above r_ptr, wrapping modulo NREQ.
    always_comb begin
        logic [IDW:0] sum;
        w_found  = 1'b0;
        w_winner = '0;
        sum      = '0;
        for (int unsigned i = 0; i < NREQ_U; i++) begin
            sum = {1'b0, r_ptr} + (IDW + 1)'(i);
            if (sum >= NREQ_W) begin
                sum = sum - NREQ_W;
            end
            if (!w_found && req[sum[IDW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = sum[IDW-1:0];
            end
        end
    end

    // Transition logic: every output value is decided by the transition taken.
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_owner     = r_owner;
        w_nxt_ptr       = r_ptr;
        w_nxt_cnt       = r_cnt;
        w_nxt_gnt       = r_gnt;
        w_nxt_gnt_id    = r_gnt_id;
        w_nxt_last_beat = 1'b0;
        w_nxt_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_nxt_gnt    = '0;
                w_nxt_gnt_id = '0;
                w_nxt_cnt    = '0;
                if (w_found) begin
                    w_nxt_state     = ST_RUN;
                    w_nxt_owner     = w_winner;
                    w_nxt_gnt       = ONE_N << w_winner;
                    w_nxt_gnt_id    = w_winner;
                    w_nxt_cnt       = CW'(1);
                    w_nxt_last_beat = (MAXBURST == 1);
                end
            end
            ST_RUN: begin
                if (req[r_owner] && (r_cnt < MAXB_C)) begin
                    w_nxt_cnt       = r_cnt + CW'(1);
                    w_nxt_last_beat = ((r_cnt + CW'(1)) == MAXB_C);
                end else begin
                    w_nxt_state  = ST_LAST;
                    w_nxt_gnt    = '0;
                    w_nxt_gnt_id = '0;
                    w_nxt_cnt    = '0;
                    w_nxt_done   = 1'b1;
                    // Explicit wrap so non-power-of-two NREQ never leaves range.
                    w_nxt_ptr    = (r_owner == LAST_ID) ? '0 : r_owner + IDW'(1);
                end
            end
            ST_LAST: begin
                w_nxt_state  = ST_IDLE;
                w_nxt_gnt    = '0;
                w_nxt_gnt_id = '0;
                w_nxt_cnt    = '0;
            end
            default: begin
                w_nxt_state  = ST_IDLE;
                w_nxt_gnt    = '0;
                w_nxt_gnt_id = '0;
                w_nxt_cnt    = '0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_owner     <= '0;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_last_beat <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_owner     <= w_nxt_owner;
            r_ptr       <= w_nxt_ptr;
            r_cnt       <= w_nxt_cnt;
            r_gnt       <= w_nxt_gnt;
            r_gnt_id    <= w_nxt_gnt_id;
            r_last_beat <= w_nxt_last_beat;
            r_done      <= w_nxt_done;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign last_beat = r_last_beat;
    assign done      = r_done;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ontransit_rr_arb.sv
// Directed bench for ontransit_rr_arb: a 4-requester/MAXBURST=4 instance and a
// 3-requester/MAXBURST=1 instance, checked cycle by cycle against hand values.
module tb_ontransit_rr_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0_n, lb0, done0, busy0;
    logic [3:0] req0, gnt0;
    logic [1:0] id0;

    logic       rst1_n, lb1, done1, busy1;
    logic [2:0] req1, gnt1;
    logic [1:0] id1;

    int n_tests = 0;
    int n_fail  = 0;

    ontransit_rr_arb #(.NREQ(4), .MAXBURST(4)) u_dut0 (
        .clk(clk), .rst_n(rst0_n), .req(req0), .gnt(gnt0), .gnt_id(id0),
        .last_beat(lb0), .done(done0), .busy(busy0)
    );

    ontransit_rr_arb #(.NREQ(3), .MAXBURST(1)) u_dut1 (
        .clk(clk), .rst_n(rst1_n), .req(req1), .gnt(gnt1), .gnt_id(id1),
        .last_beat(lb1), .done(done1), .busy(busy1)
    );

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       lb;
        logic       dn;
        logic       bz;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic [3:0] q, logic [3:0] g, logic [1:0] i,
                                logic l, logic d, logic b);
        vec_t v;
        v.rst_n = r; v.req = q; v.gnt = g; v.id = i; v.lb = l; v.dn = d; v.bz = b;
        return v;
    endfunction

    // Packed view: {gnt[3:0], id[1:0], last_beat, done, busy}
    task automatic check(input string nm, input logic [8:0] act, input logic [8:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got gnt=%b id=%0d lb=%b done=%b busy=%b, want gnt=%b id=%0d lb=%b done=%b busy=%b",
                     nm, act[8:5], act[4:3], act[2], act[1], act[0],
                     exp[8:5], exp[4:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic step0(input logic r, input logic [3:0] q);
        rst0_n = r;
        req0   = q;
        @(posedge clk);
        #1;
    endtask

    task automatic step1(input logic r, input logic [2:0] q);
        rst1_n = r;
        req1   = q;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] act0();
        return {gnt0, id0, lb0, done0, busy0};
    endfunction

    function automatic logic [8:0] act1();
        return {1'b0, gnt1, id1, lb1, done1, busy1};
    endfunction

    initial begin
        logic [3:0] eg;
        int         own;
        int         p;

        rst0_n = 1'b0; req0 = '0;
        rst1_n = 1'b0; req1 = '0;

        // Reset with all requesting, then first grant to requester 0.
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'b1111, 4'b0001, 0, 0, 0, 1));
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 1, 1));
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0));
        // Single held request on requester 2: full burst, done, regrant.
        tbl.push_back(mk(1, 4'b0100, 4'b0100, 2, 0, 0, 1));
        tbl.push_back(mk(1, 4'b0100, 4'b0100, 2, 0, 0, 1));
        tbl.push_back(mk(1, 4'b0100, 4'b0100, 2, 0, 0, 1));
        tbl.push_back(mk(1, 4'b0100, 4'b0100, 2, 1, 0, 1));
        tbl.push_back(mk(1, 4'b0100, 4'b0000, 0, 0, 1, 1));
        tbl.push_back(mk(1, 4'b0100, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0100, 4'b0100, 2, 0, 0, 1));
        tbl.push_back(mk(1, 4'b0100, 4'b0100, 2, 0, 0, 1));
        tbl.push_back(mk(1, 4'b0100, 4'b0100, 2, 0, 0, 1));
        tbl.push_back(mk(1, 4'b0100, 4'b0100, 2, 1, 0, 1));
        tbl.push_back(mk(1, 4'b0100, 4'b0000, 0, 0, 1, 1));
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0));
        // Early release of requester 1 after three request cycles.
        tbl.push_back(mk(1, 4'b0010, 4'b0010, 1, 0, 0, 1));
        tbl.push_back(mk(1, 4'b0010, 4'b0010, 1, 0, 0, 1));
        tbl.push_back(mk(1, 4'b0010, 4'b0010, 1, 0, 0, 1));
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 1, 1));
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0));
        // Rotation from ptr=2, wrap of ptr past 3, requests ignored in LAST.
        tbl.push_back(mk(1, 4'b1010, 4'b1000, 3, 0, 0, 1));
        tbl.push_back(mk(1, 4'b0010, 4'b0000, 0, 0, 1, 1));
        tbl.push_back(mk(1, 4'b0010, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0010, 4'b0010, 1, 0, 0, 1));
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 1, 1));
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            step0(tbl[i].rst_n, tbl[i].req);
            check($sformatf("tbl[%0d]", i), act0(),
                  {tbl[i].gnt, tbl[i].id, tbl[i].lb, tbl[i].dn, tbl[i].bz});
        end

        // All requesting from a fresh reset: owners 0,1,2,3,0 with period 6.
        step0(0, 4'b0000);
        check("allreq_rst", act0(), 9'b0);
        for (int c = 0; c < 30; c++) begin
            step0(1, 4'b1111);
            p   = c % 6;
            own = (c / 6) % 4;
            eg  = 4'b0001 << own;
            if (p < 4)
                check($sformatf("allreq[%0d]", c), act0(), {eg, 2'(own), (p == 3), 1'b0, 1'b1});
            else if (p == 4)
                check($sformatf("allreq[%0d]", c), act0(), {4'b0000, 2'd0, 1'b0, 1'b1, 1'b1});
            else
                check($sformatf("allreq[%0d]", c), act0(), 9'b0);
        end

        // Mid-burst reset (ptr was 1): no done, next winner chosen from ptr=0.
        step0(1, 4'b0100);
        check("mid_c1", act0(), {4'b0100, 2'd2, 1'b0, 1'b0, 1'b1});
        step0(1, 4'b0100);
        check("mid_c2", act0(), {4'b0100, 2'd2, 1'b0, 1'b0, 1'b1});
        step0(1, 4'b0100);
        check("mid_c3", act0(), {4'b0100, 2'd2, 1'b0, 1'b0, 1'b1});
        step0(0, 4'b0100);
        check("mid_rst", act0(), 9'b0);
        step0(1, 4'b1111);
        check("mid_after", act0(), {4'b0001, 2'd0, 1'b0, 1'b0, 1'b1});
        step0(1, 4'b0000);
        check("mid_done", act0(), {4'b0000, 2'd0, 1'b0, 1'b1, 1'b1});
        step0(1, 4'b0000);
        check("mid_idle", act0(), 9'b0);
        rst0_n = 1'b0;

        // MAXBURST=1, NREQ=3: grants alternate 0 and 2, period 3, last_beat each.
        step1(0, 3'b000);
        check("mb1_rst", act1(), 9'b0);
        for (int c = 0; c < 12; c++) begin
            step1(1, 3'b101);
            p   = c % 3;
            own = ((c / 3) % 2 == 0) ? 0 : 2;
            eg  = 4'b0001 << own;
            if (p == 0)
                check($sformatf("mb1[%0d]", c), act1(), {eg, 2'(own), 1'b1, 1'b0, 1'b1});
            else if (p == 1)
                check($sformatf("mb1[%0d]", c), act1(), {4'b0000, 2'd0, 1'b0, 1'b1, 1'b1});
            else
                check($sformatf("mb1[%0d]", c), act1(), 9'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
